// File: rtl/ppe_pkg.sv
// ppe_pkg: shared state type, weight floor and one-hot helpers for the weighted round-robin arbiter.
package ppe_pkg;
  typedef enum logic {ARB, PKT} ppe_state_e;
  localparam int WEIGHT_MIN = 1;
  localparam int MAX_N = 32;
  localparam int MAX_W = $clog2(MAX_N);
  typedef logic [0:MAX_N-1] ppe_vec_t;
  // Moves bit i to bit i+1, so bit n-1 wraps to bit 0
  function automatic ppe_vec_t rotate_r(input ppe_vec_t v, input int n);
    ppe_vec_t r;
    r = '0;
    for (int i = 0; i < MAX_N; i++)
      if (i < n) r[MAX_W'((i + 1) % n)] = v[MAX_W'(i)];
    return r;
  endfunction
  function automatic int onehot2idx(input ppe_vec_t v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_N; i++)
      if (v[MAX_W'(i)]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/ppe_slice_chain.sv
// ppe_slice_chain: combinational programmable priority encoder; the carry ring is unrolled twice to avoid a loop.
module ppe_slice_chain #(
  parameter int N = 5
) (
  input  logic [0:N-1] i_request,
  input  logic [0:N-1] i_priority,
  output logic [0:N-1] o_grant
);
  localparam int IW = $clog2(N);
  logic carry;
  always_comb begin
    carry = 1'b0;
    o_grant = '0;
    for (int k = 0; k < 2 * N; k++) begin
      carry = carry | (k < N && i_priority[IW'(k % N)]);
      o_grant[IW'(k % N)] = o_grant[IW'(k % N)] | (carry & i_request[IW'(k % N)]);
      carry = carry & ~i_request[IW'(k % N)];
    end
  end
endmodule

// File: rtl/ppe_wrr_arbiter.sv
// ppe_wrr_arbiter: N-way weighted round-robin arbiter with packet locking and a valid/ready output.
// Define PPE_WRR_TIMEOUT_EN to add a watchdog that force-releases a lock stalled for TIMEOUT ce-cycles.
module ppe_wrr_arbiter
  import ppe_pkg::*;
#(
  parameter int N        = 5,
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [0:N-1]        i_request,
  input  logic [0:N-1]        i_tail,
  input  logic [WEIGHT_W-1:0] i_weight [N],
  input  logic                i_ready,
  output logic [0:N-1]        o_grant,
  output logic                o_valid,
  output logic                o_locked,
  output logic                o_timeout
);
  localparam int IW = $clog2(N);
  localparam logic [0:N-1] PRI_RST = {1'b1, {(N - 1){1'b0}}};
  ppe_state_e state_q, state_d;
  logic [0:N-1] pri_q, pri_d, owner_q, owner_d, ppe_grant;
  logic [WEIGHT_W-1:0] credit_q, credit_d, wsel, base, dec;
  logic [IW-1:0] win;
  ppe_vec_t owner_pad, rot;
  logic xfer, tail_w, tmo, unused_rot;

  ppe_slice_chain #(.N(N)) u_chain (
    .i_request (i_request),
    .i_priority(pri_q),
    .o_grant   (ppe_grant)
  );

  assign o_grant = !reset_n ? '0 : state_q == PKT ? owner_q & i_request : ppe_grant;
  assign o_valid = |o_grant;
  assign o_locked = reset_n && state_q == PKT;
  assign o_timeout = tmo;
  assign xfer = ce && o_valid && i_ready;
  assign tail_w = |(o_grant & i_tail);
  assign owner_d = xfer ? o_grant : owner_q;
  // owner_d equals the winner on xfer and the stalled owner on watchdog release, so it feeds both helpers
  always_comb begin
    owner_pad = '0;
    owner_pad[0:N-1] = owner_d;
  end
  assign rot = rotate_r(owner_pad, N);
  assign unused_rot = ^rot;
  assign win = IW'(onehot2idx(owner_pad));
  assign wsel = i_weight[win];
  // An exhausted credit reloads even for the same owner, so a lone requester never wraps the counter
  assign base = (o_grant != owner_q || credit_q == '0) ? (wsel == '0 ? WEIGHT_W'(WEIGHT_MIN) : wsel) : credit_q;
  assign dec = base - WEIGHT_W'(1);

  always_comb begin
    state_d = xfer ? (tail_w ? PKT == PKT ? ARB : PKT : PKT) : tmo ? ARB : state_q;
    pri_d = (xfer && tail_w && dec == '0) || tmo ? rot[0:N-1] : xfer && tail_w ? o_grant : pri_q;
    credit_d = tmo ? '0 : !xfer ? credit_q : tail_w ? dec : base;
  end

`ifdef PPE_WRR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_q, wd_d;
  logic idle;
  assign idle = reset_n && ce && state_q == PKT && !xfer;
  assign tmo = idle && wd_q == WD_W'(TIMEOUT - 1);
  assign wd_d = !ce ? wd_q : idle && !tmo ? wd_q + WD_W'(1) : '0;
  always_ff @(posedge clk) wd_q <= !reset_n ? '0 : wd_d;
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ARB;
      pri_q    <= PRI_RST;
      owner_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      pri_q    <= pri_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end
endmodule

// File: tb/tb_ppe_wrr_arbiter.sv
// tb_ppe_wrr_arbiter: directed checks of grant order, weights, locking, stalls, ce, wrap, reset and watchdog.
module tb_ppe_wrr_arbiter;
  logic clk = 1'b0;
  logic reset_n, ce, i_ready;
  logic [0:3] i_request, i_tail, o_grant;
  logic [3:0] wt [4];
  logic o_valid, o_locked, o_timeout;
  int total = 0;
  int bad = 0;

  ppe_wrr_arbiter #(.N(4), .WEIGHT_W(4), .TIMEOUT(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .i_request(i_request),
    .i_tail   (i_tail),
    .i_weight (wt),
    .i_ready  (i_ready),
    .o_grant  (o_grant),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [0:3] req, input logic [0:3] tl,
                      input logic [0:3] exp_g, input logic exp_lk, input logic exp_to);
    i_request = req;
    i_tail = tl;
    @(negedge clk);
    chk(tag, 32'(o_grant), 32'(exp_g));
    chk({tag, "_valid"}, 32'(o_valid), 32'(|exp_g));
    chk({tag, "_locked"}, 32'(o_locked), 32'(exp_lk));
    chk({tag, "_timeout"}, 32'(o_timeout), 32'(exp_to));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_request = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [0:3] exp_wrr [9] = '{4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0010,
                              4'b0001, 4'b1000, 4'b1000, 4'b1000};

  initial begin
    reset_n = 1'b0;
    ce = 1'b1;
    i_ready = 1'b1;
    i_request = '0;
    i_tail = '0;
    wt = '{4'd1, 4'd1, 4'd1, 4'd1};
    @(posedge clk);
    #1;
    i_request = 4'b1111;
    @(negedge clk);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("rr0", 4'b1111, 4'b1111, 4'b1000, 1'b0, 1'b0);
    step("rr1", 4'b1111, 4'b1111, 4'b0100, 1'b0, 1'b0);
    step("rr2", 4'b1111, 4'b1111, 4'b0010, 1'b0, 1'b0);
    step("rr3", 4'b1111, 4'b1111, 4'b0001, 1'b0, 1'b0);
    step("rr4", 4'b1111, 4'b1111, 4'b1000, 1'b0, 1'b0);
    wt = '{4'd3, 4'd1, 4'd1, 4'd1};
    do_reset();
    for (int i = 0; i < 9; i++) step("wrr", 4'b1111, 4'b1111, exp_wrr[i], 1'b0, 1'b0);
    wt = '{4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    step("pk0", 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
    step("pk1", 4'b1100, 4'b0100, 4'b1000, 1'b1, 1'b0);
    step("pk2", 4'b1100, 4'b1100, 4'b1000, 1'b1, 1'b0);
    step("pk3", 4'b1100, 4'b1100, 4'b0100, 1'b0, 1'b0);
    wt = '{4'd1, 4'd1, 4'd2, 4'd1};
    do_reset();
    i_ready = 1'b0;
    repeat (4) step("stall", 4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0);
    i_ready = 1'b1;
    step("rs0", 4'b0011, 4'b0011, 4'b0010, 1'b0, 1'b0);
    step("rs1", 4'b0011, 4'b0011, 4'b0010, 1'b0, 1'b0);
    step("rs2", 4'b0011, 4'b0011, 4'b0001, 1'b0, 1'b0);
    ce = 1'b0;
    step("ce_off0", 4'b1001, 4'b1001, 4'b1000, 1'b0, 1'b0);
    step("ce_off1", 4'b1001, 4'b1001, 4'b1000, 1'b0, 1'b0);
    ce = 1'b1;
    step("ce_on0", 4'b1001, 4'b1001, 4'b1000, 1'b0, 1'b0);
    step("ce_on1", 4'b1001, 4'b1001, 4'b0001, 1'b0, 1'b0);
    wt = '{4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    step("wrap0", 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    step("wrap1", 4'b1001, 4'b1001, 4'b1000, 1'b0, 1'b0);
    do_reset();
    step("mp0", 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0);
    step("mp1", 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0);
    reset_n = 1'b0;
    i_request = 4'b0010;
    @(negedge clk);
    chk("mp_rst_grant", 32'(o_grant), 32'd0);
    chk("mp_rst_locked", 32'(o_locked), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("mp2", 4'b0110, 4'b0110, 4'b0100, 1'b0, 1'b0);
    do_reset();
    step("lk0", 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0);
`ifdef PPE_WRR_TIMEOUT_EN
    for (int i = 0; i < 7; i++) step("wd_idle", 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0);
    step("wd_pulse", 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
    step("wd_next", 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
`else
    for (int i = 0; i < 10; i++) step("hold", 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
